mul_ctrl: RTL and testbench
===========================

# mul_ctrl

Multi-cycle sequencer for the RV32M multiply unit. It accepts one multiply request at a time from the execute stage and drives the existing 17-row radix-4 Booth partial-product generator. It reduces the 17 rows into a 64-bit accumulator at four rows per cycle, applies the MULHSU sign correction, and returns the selected 32-bit half with the destination tag. It sits between the issue/execute logic and writeback, using a valid/ready handshake on both sides.

## Interface
- `TAG_W`, 5: width of the destination tag carried through.
- `ROWS_PER_CYC`, 4: Booth rows summed per accumulate cycle. Fixed at 4 in this revision.
- `clk`  in  1  sole clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  controller can accept a request.
- `in_op`  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- `in_rs1`  in  32  multiplicand.
- `in_rs2`  in  32  multiplier.
- `in_tag`  in  TAG_W  destination tag.
- `flush`  in  1  kill any in-flight operation.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  32  result.
- `out_tag`  out  TAG_W  tag of the result.
- `busy`  out  1  state is not IDLE.

## Operation
- **States:** IDLE, ACC, FIN, DONE. Reset puts the block in IDLE with `out_valid`=0, `out_data`=0, `out_tag`=0, accumulator=0, `row_idx`=0. `in_ready`=1 in IDLE.
- **Accept:** on `in_valid && in_ready && !flush`, latch op, rs1, rs2 and tag. Clear the accumulator, clear `row_idx`, and go to ACC.
- **Booth `signed_flag`:**
  - 1 for MUL, MULH and MULHSU.
  - 0 for MULHU.
  - MUL low half is sign-independent.
- **ACC:** each cycle, acc += Σ over rows r in [4k, min(4k+3, 16)] of (p[r] + (c[r] << 2r)), truncated to 64 bits.
  - k = `row_idx`, values 0..4. k=4 adds row 16 only.
  - `row_idx` increments each cycle. After k=4, go to FIN.
- **FIN:**
  - If op=MULHSU and rs2[31]=1, acc += sext64(rs1) << 32, mod 2^64. This corrects the signed×signed product to signed×unsigned.
  - Select acc[31:0] for MUL and acc[63:32] otherwise.
  - Register the selection into `out_data`, copy the tag to `out_tag`, set `out_valid`=1, and go to DONE.
- **DONE:**
  - Hold `out_valid`, `out_data` and `out_tag` stable until `out_ready`.
  - `in_ready` = `out_ready` in this state, so a new request can be accepted in the same cycle the result is consumed. That case goes directly to ACC; otherwise the block goes to IDLE.
- **`flush`:**
  - Next state is IDLE, `out_valid` is cleared, and no request is accepted in the flush cycle.
  - If `out_valid && out_ready` are high in the flush cycle, that transfer counts as completed.
  - `flush` while IDLE has no effect.
- **Reset mid-operation:** the block goes to IDLE immediately and produces no result.
- **Input stability:** inputs are sampled only at acceptance, so the requester may change them afterwards.

## Timing
- **Latency:** accept edge E0, accumulate edges E1–E5, FIN edge E6. `out_valid` is high after E6, so an accepted request gives its result 6 cycles later.
- **Throughput:** with `out_ready` held at 1, one result every 7 cycles (accept in DONE, then ACC directly).
- **Registered outputs:** `out_valid`, `out_data` and `out_tag`. `in_ready` and `busy` are combinational from state and `out_ready`.

## Structure
- **Shared package `mul_pkg`:**
  - op encodings MUL/MULH/MULHSU/MULHU
  - state encoding
  - ROWS=17
  - ACC_CYCLES=5
- **Sub-module:** a single instance of the existing Booth 17-row partial-product generator, driven from the latched operands. Row/carry selection muxes and the 64-bit adder tree for four rows live in `mul_ctrl`.

## Test plan
- **MUL:** rs1=7, rs2=6 → `out_data`=0x0000002A, `out_tag` matches, `out_valid` exactly 6 cycles after acceptance.
- **MULH:** rs1=rs2=0x80000000 → 0x40000000. **MULHU:** rs1=rs2=0xFFFFFFFF → 0xFFFFFFFE. **MUL** on the same operands → 0x00000001.
- **MULHSU:** rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → 0xFFFFFFFF. With rs1=0x00000002, rs2=0x80000000 → 0x00000001.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE → outputs stable and `in_ready`=0. Then assert `out_ready` with `in_valid` high → result consumed and new request accepted in the same cycle.
- **Flush:** assert `flush` at cycle 3 of ACC → IDLE next cycle, `out_valid` never asserted for that tag, next request gives a correct result.
- **Async reset:** assert `rst` mid-ACC → all outputs 0 and `in_ready`=1 without waiting for a clock edge. A random 1000-op regression against a 64-bit reference model shows zero mismatches.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the RV32M multiply sequencer.
//   op_e      : funct3[1:0] encodings of the multiply ops
//   state_e   : sequencer FSM states
//   ROWS      : Booth partial-product rows for a 33x33-bit product
//   ACC_CYCLES: accumulate cycles needed to sum all rows
package mul_pkg;

   typedef enum logic [1:0] {
      OpMul    = 2'b00,
      OpMulh   = 2'b01,
      OpMulhsu = 2'b10,
      OpMulhu  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StAcc  = 2'b01,
      StFin  = 2'b10,
      StDone = 2'b11
   } state_e;

   localparam int unsigned ROWS       = 17;
   localparam int unsigned ACC_CYCLES = 5;
   localparam int unsigned RIDX_W     = 3;

   // Booth encoding treats both operands as signed except for MULHU.
   // MULHSU is fixed up afterwards by the sign correction in FIN.
   function automatic logic booth_signed(op_e op);
      return op != OpMulhu;
   endfunction

endpackage

// File: rtl/mul_ctrl_booth.sv
// mul_ctrl_booth: radix-4 Booth partial-product generator, 17 rows.
//   mcand_i  : multiplicand (rs1)
//   mplier_i : multiplier (rs2)
//   signed_i : 1 = treat both operands as signed, 0 = unsigned
//   pp_o[r]  : row r, already shifted left by 2r, one's-complemented when negative
//   neg_o[r] : row r is negative; the +1 completing the negation is added at bit 2r
// Sum over r of pp_o[r] + (neg_o[r] << 2r) equals the full product mod 2^64.
module mul_ctrl_booth
   import mul_pkg::*;
(
   input  logic [31:0]              mcand_i,
   input  logic [31:0]              mplier_i,
   input  logic                     signed_i,
   output logic [ROWS-1:0][63:0]    pp_o,
   output logic [ROWS-1:0]          neg_o
);

   logic [63:0] x_ext;
   logic [34:0] y_ext;   // {ext, ext, mplier, implicit 0 below bit 0}
   logic [2:0]  bits;
   logic [63:0] mag;

   always_comb begin
      x_ext = {{32{signed_i & mcand_i[31]}}, mcand_i};
      y_ext = {{2{signed_i & mplier_i[31]}}, mplier_i, 1'b0};
      bits  = '0;
      mag   = '0;
      pp_o  = '0;
      neg_o = '0;
      for (int r = 0; r < int'(ROWS); r++) begin
         bits = y_ext[2*r+2 -: 3];
         unique case (bits)
            3'b001, 3'b010, 3'b101, 3'b110: mag = x_ext;
            3'b011, 3'b100:                 mag = x_ext << 1;
            default:                        mag = '0;
         endcase
         neg_o[r] = bits[2] & ~(bits[1] & bits[0]);
         pp_o[r]  = (neg_o[r] ? ~mag : mag) << (2 * r);
      end
   end

endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: multi-cycle sequencer for the RV32M multiply unit.
// Accepts one request, accumulates 17 Booth rows four per cycle into a 64-bit
// accumulator, applies the MULHSU correction and returns the selected half.
//   clk, rst         : clock, asynchronous active-high reset
//   in_valid/in_ready: request handshake; in_op/in_rs1/in_rs2/in_tag sampled on accept
//   flush            : abort any in-flight operation and drop a pending result
//   out_valid/ready  : result handshake; out_data/out_tag registered
//   busy             : controller is not idle
module mul_ctrl
   import mul_pkg::*;
#(
   parameter int unsigned TAG_W        = 5,
   parameter int unsigned ROWS_PER_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_rs1,
   input  logic [31:0]      in_rs2,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   state_e              state_q;
   op_e                 op_q;
   logic [31:0]         rs1_q;
   logic [31:0]         rs2_q;
   logic [TAG_W-1:0]    tag_q;
   logic [63:0]         acc_q;
   logic [RIDX_W-1:0]   row_idx_q;

   logic [ROWS-1:0][63:0] pp;
   logic [ROWS-1:0]       neg;
   logic [63:0]           row_sum;
   logic [4:0]            row_sel;
   logic [63:0]           fin_acc;
   logic [31:0]           fin_sel;
   logic                  accept;

   mul_ctrl_booth u_booth (
      .mcand_i  (rs1_q),
      .mplier_i (rs2_q),
      .signed_i (booth_signed(op_q)),
      .pp_o     (pp),
      .neg_o    (neg)
   );

   assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
   assign busy     = (state_q != StIdle);
   assign accept   = in_valid && in_ready && !flush;

   // Sum of the rows selected by row_idx_q; rows past 16 contribute nothing.
   always_comb begin
      row_sum = '0;
      row_sel = '0;
      for (int j = 0; j < int'(ROWS_PER_CYC); j++) begin
         row_sel = 5'(32'(row_idx_q) * ROWS_PER_CYC + 32'(j));
         if (32'(row_sel) < ROWS) begin
            row_sum = row_sum + pp[row_sel] + (64'(neg[row_sel]) << {row_sel, 1'b0});
         end
      end
   end

   // Signed x signed -> signed x unsigned: add rs1 * 2^32 when rs2 is "negative".
   always_comb begin
      fin_acc = acc_q;
      if ((op_q == OpMulhsu) && rs2_q[31]) begin
         fin_acc = acc_q + {rs1_q, 32'h0};
      end
      fin_sel = (op_q == OpMul) ? fin_acc[31:0] : fin_acc[63:32];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         op_q      <= OpMul;
         rs1_q     <= '0;
         rs2_q     <= '0;
         tag_q     <= '0;
         acc_q     <= '0;
         row_idx_q <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tag   <= '0;
      end else begin
         if (accept) begin
            op_q      <= op_e'(in_op);
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            tag_q     <= in_tag;
            acc_q     <= '0;
            row_idx_q <= '0;
         end
         unique case (state_q)
            StIdle: begin
               if (accept) state_q <= StAcc;
            end
            StAcc: begin
               if (flush) begin
                  state_q <= StIdle;
               end else begin
                  acc_q     <= acc_q + row_sum;
                  row_idx_q <= row_idx_q + 1'b1;
                  if (row_idx_q == RIDX_W'(ACC_CYCLES - 1)) state_q <= StFin;
               end
            end
            StFin: begin
               if (flush) begin
                  state_q <= StIdle;
               end else begin
                  out_data  <= fin_sel;
                  out_tag   <= tag_q;
                  out_valid <= 1'b1;
                  state_q   <= StDone;
               end
            end
            StDone: begin
               // A transfer with out_ready high still completes under flush.
               if (flush) begin
                  out_valid <= 1'b0;
                  state_q   <= StIdle;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= accept ? StAcc : StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_ctrl.sv
module tb_mul_ctrl;
   import mul_pkg::*;

   localparam int unsigned TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_rs1;
   logic [31:0]      in_rs2;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   mul_ctrl #(.TAG_W(TAG_W), .ROWS_PER_CYC(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_tag    (in_tag),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      op_e         op;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  tag;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input op_e op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] xa, xb, p;
      xa = (op == OpMulhu) ? {32'h0, a} : {{32{a[31]}}, a};
      xb = (op == OpMulhu || op == OpMulhsu) ? {32'h0, b} : {{32{b[31]}}, b};
      p  = xa * xb;
      return (op == OpMul) ? p[31:0] : p[63:32];
   endfunction

   // Present a request for one edge, then scramble the inputs.
   task automatic issue(input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      in_valid = 1'b1;
      in_op    = op;
      in_rs1   = a;
      in_rs2   = b;
      in_tag   = tag;
      @(negedge clk);
      in_valid = 1'b0;
      in_op    = 2'($urandom);
      in_rs1   = $urandom;
      in_rs2   = $urandom;
      in_tag   = 5'($urandom);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_op(input string name, input op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp);
      int n;
      chk({name, " in_ready"}, 32'(in_ready), 32'd1);
      issue(op, a, b, tag);
      wait_valid(n);
      chk({name, " latency"}, 32'(n), 32'd6);
      chk({name, " data"}, out_data, exp);
      chk({name, " tag"}, 32'(out_tag), 32'(tag));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, " consumed"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int n;
      logic seen;
      op_e rop;
      logic [31:0] ra, rb;

      vecs[0]  = '{OpMul,    32'd7,        32'd6,        5'd3,  32'h0000002A};
      vecs[1]  = '{OpMulh,   32'h80000000, 32'h80000000, 5'd4,  32'h40000000};
      vecs[2]  = '{OpMulhu,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE};
      vecs[3]  = '{OpMul,    32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000001};
      vecs[4]  = '{OpMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFF};
      vecs[5]  = '{OpMulhsu, 32'h00000002, 32'h80000000, 5'd8,  32'h00000001};
      vecs[6]  = '{OpMulh,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'h00000000};
      vecs[7]  = '{OpMulh,   32'hFFFFFFFF, 32'h00000002, 5'd10, 32'hFFFFFFFF};
      vecs[8]  = '{OpMulhu,  32'h80000000, 32'h00000002, 5'd11, 32'h00000001};
      vecs[9]  = '{OpMul,    32'h12345678, 32'h00000010, 5'd12, 32'h23456780};
      vecs[10] = '{OpMulhsu, 32'h80000000, 32'h00000002, 5'd13, 32'hFFFFFFFF};
      vecs[11] = '{OpMulhu,  32'h00010000, 32'h00010000, 5'd14, 32'h00000001};
      vecs[12] = '{OpMul,    32'h00000000, 32'hDEADBEEF, 5'd15, 32'h00000000};
      vecs[13] = '{OpMulh,   32'h7FFFFFFF, 32'h7FFFFFFF, 5'd31, 32'h3FFFFFFF};

      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0;
      in_tag = '0; flush = 1'b0; out_ready = 1'b0;
      #12;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data",  out_data,       32'd0);
      chk("reset out_tag",   32'(out_tag),   32'd0);
      chk("reset in_ready",  32'(in_ready),  32'd1);
      chk("reset busy",      32'(busy),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].rs2,
                vecs[i].tag, vecs[i].exp);
      end

      // Backpressure, then consume and accept in the same cycle.
      issue(OpMulhu, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd21);
      wait_valid(n);
      chk("bp latency", 32'(n), 32'd6);
      for (int i = 0; i < 10; i++) begin
         chk("bp hold valid", 32'(out_valid), 32'd1);
         chk("bp hold data",  out_data,       32'hFFFFFFFE);
         chk("bp hold tag",   32'(out_tag),   32'd21);
         chk("bp in_ready",   32'(in_ready),  32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("bp in_ready follows out_ready", 32'(in_ready), 32'd1);
      issue(OpMul, 32'd7, 32'd6, 5'd22);
      out_ready = 1'b0;
      chk("bp consumed", 32'(out_valid), 32'd0);
      chk("bp new busy", 32'(busy),      32'd1);
      wait_valid(n);
      chk("bp2 latency", 32'(n), 32'd6);
      chk("bp2 data", out_data, 32'h0000002A);
      chk("bp2 tag", 32'(out_tag), 32'd22);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Flush during the third accumulate cycle.
      issue(OpMul, 32'd3, 32'd5, 5'd9);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush acc busy",     32'(busy),     32'd0);
      chk("flush acc in_ready", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         seen = seen | out_valid;
         @(negedge clk);
      end
      chk("flush acc no result", 32'(seen), 32'd0);
      run_op("after flush", OpMul, 32'd3, 32'd5, 5'd10, 32'd15);

      // Flush while idle blocks acceptance and otherwise does nothing.
      flush = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush idle busy", 32'(busy), 32'd0);

      // Flush while a result is waiting drops it.
      issue(OpMulh, 32'h80000000, 32'h80000000, 5'd17);
      wait_valid(n);
      chk("flush done latency", 32'(n), 32'd6);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush done valid", 32'(out_valid), 32'd0);
      chk("flush done busy",  32'(busy),      32'd0);

      // Asynchronous reset in the middle of accumulation.
      issue(OpMulhu, 32'h12345678, 32'h9ABCDEF0, 5'd19);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst out_valid", 32'(out_valid), 32'd0);
      chk("async rst out_data",  out_data,       32'd0);
      chk("async rst out_tag",   32'(out_tag),   32'd0);
      chk("async rst in_ready",  32'(in_ready),  32'd1);
      chk("async rst busy",      32'(busy),      32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op("after rst", OpMulhsu, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFF);

      // Random regression against the 64-bit reference.
      for (int i = 0; i < 1000; i++) begin
         rop = op_e'($urandom_range(0, 3));
         ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         rb  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
         run_op($sformatf("rnd%0d", i), rop, ra, rb, 5'($urandom), ref_mul(rop, ra, rb));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
